// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch next-PC controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    WAIT_JBASE = 2'd2,
    RECOVER    = 2'd3
  } ctrl_state_t;

  typedef enum logic [2:0] {
    SEL_SEQ   = 3'd0,
    SEL_BRNCH = 3'd1,
    SEL_JIMM  = 3'd2,
    SEL_JREG  = 3'd3,
    SEL_RECOV = 3'd4,
    SEL_HOLD  = 3'd5,
    SEL_EXTER = 3'd6
  } pc_sel_t;

  localparam int unsigned FETCH_STRIDE = 4;

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage control bus: redirect sources in, fetch address and status out.
interface fetch_pc_ctrl_if #(
  parameter int unsigned PC_WIDTH = 16
);
  logic                stall_fetch;
  logic                has_mispredict;
  logic [PC_WIDTH-1:0] pc_recovery;
  logic                exter_pc_en;
  logic [PC_WIDTH-1:0] exter_pc;
  logic [1:0]          brnch_issue;
  logic                brnch_tkn;
  logic [PC_WIDTH-1:0] brnch_target;
  logic                decr_count_brnch;
  logic                jump_imm;
  logic [PC_WIDTH-1:0] jump_imm_target;
  logic                jump_reg;
  logic                jump_base_rdy_from_rf;
  logic [PC_WIDTH-1:0] jump_base_from_rf;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic                fetch_valid;
  logic                flush_fetch;
  logic [2:0]          pc_select;
  logic                brch_full;
  logic [1:0]          ctrl_state;

  modport master (
    output stall_fetch, has_mispredict, pc_recovery, exter_pc_en, exter_pc,
           brnch_issue, brnch_tkn, brnch_target, decr_count_brnch,
           jump_imm, jump_imm_target, jump_reg, jump_base_rdy_from_rf,
           jump_base_from_rf,
    input  fetch_pc, fetch_valid, flush_fetch, pc_select, brch_full, ctrl_state
  );

  modport slave (
    input  stall_fetch, has_mispredict, pc_recovery, exter_pc_en, exter_pc,
           brnch_issue, brnch_tkn, brnch_target, decr_count_brnch,
           jump_imm, jump_imm_target, jump_reg, jump_base_rdy_from_rf,
           jump_base_from_rf,
    output fetch_pc, fetch_valid, flush_fetch, pc_select, brch_full, ctrl_state
  );
endinterface

// File: rtl/fetch_pc_ctrl_brnch_inflight_cnt.sv
// Counts predicted branches in flight; flags full when fewer than two slots remain.
module brnch_inflight_cnt #(
  parameter int unsigned MAX_BRNCH = 4,
  localparam int unsigned CNT_W    = $clog2(MAX_BRNCH + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       accepted,
  input  logic [1:0] brnch_issue,
  input  logic       decr,
  output logic       brch_full
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W:0]   sum;

  // A decrement at zero is dropped; increment and decrement net in one cycle.
  always_comb begin
    sum     = '0;
    count_d = count;
    if (clear) begin
      count_d = '0;
    end else begin
      sum = {1'b0, count}
          + (accepted ? (CNT_W+1)'(brnch_issue) : '0)
          - ((decr && (count != '0)) ? (CNT_W+1)'(1) : '0);
      count_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count_d;
  end

  assign brch_full = (count > CNT_W'(MAX_BRNCH - 2));

  a_no_decr_at_zero: assert property (
    @(posedge clk) disable iff (rst) !(decr && !clear && (count == '0))
  );

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Next-PC selection, register-jump wait and mispredict bubble for the fetch stage.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH  = 16,
  parameter int unsigned         MAX_BRNCH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic           clk,
  input  logic           rst,
  fetch_pc_ctrl_if.slave bus
);

  ctrl_state_t         state_q, state_d;
  pc_sel_t             sel;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                brch_full;
  logic                accepted;

  assign accepted = (state_q == RUN) && !bus.stall_fetch && !brch_full;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sel     = SEL_HOLD;
    if (bus.exter_pc_en) begin
      pc_d    = bus.exter_pc;
      state_d = RUN;
      sel     = SEL_EXTER;
    end else if (bus.has_mispredict) begin
      pc_d    = bus.pc_recovery;
      state_d = RECOVER;
      sel     = SEL_RECOV;
    end else begin
      case (state_q)
        IDLE:    state_d = RUN;
        RECOVER: state_d = RUN;
        WAIT_JBASE: begin
          if (bus.jump_base_rdy_from_rf) begin
            pc_d    = bus.jump_base_from_rf;
            state_d = RUN;
            sel     = SEL_JREG;
          end
        end
        RUN: begin
          if (accepted) begin
            // Register jump parks on the current PC until the base arrives.
            if (bus.jump_reg) begin
              state_d = WAIT_JBASE;
            end else if (bus.jump_imm) begin
              pc_d = bus.jump_imm_target;
              sel  = SEL_JIMM;
            end else if (bus.brnch_tkn) begin
              pc_d = bus.brnch_target;
              sel  = SEL_BRNCH;
            end else begin
              pc_d = pc_q + PC_WIDTH'(FETCH_STRIDE);
              sel  = SEL_SEQ;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  brnch_inflight_cnt #(
    .MAX_BRNCH (MAX_BRNCH)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clear       (bus.exter_pc_en || bus.has_mispredict),
    .accepted    (accepted),
    .brnch_issue (bus.brnch_issue),
    .decr        (bus.decr_count_brnch),
    .brch_full   (brch_full)
  );

  assign bus.fetch_pc    = pc_q;
  assign bus.fetch_valid = (state_q == RUN);
  assign bus.flush_fetch = (state_q == RECOVER) || (state_q == WAIT_JBASE);
  assign bus.pc_select   = sel;
  assign bus.brch_full   = brch_full;
  assign bus.ctrl_state  = state_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: per-cycle expectations queued, checked by a monitor.
module tb_fetch_pc_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_pc_ctrl_if #(.PC_WIDTH(16)) bus ();

  fetch_pc_ctrl #(
    .PC_WIDTH  (16),
    .MAX_BRNCH (4),
    .RESET_PC  (16'h0000)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic        valid;
    logic        flush;
    logic [2:0]  sel;
    logic        full;
    logic [1:0]  st;
    int          cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic cmp(input string tag, input string fld, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, fld, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.tag, "fetch_pc",    int'(bus.fetch_pc),    int'(e.pc));
      cmp(e.tag, "fetch_valid", int'(bus.fetch_valid), int'(e.valid));
      cmp(e.tag, "flush_fetch", int'(bus.flush_fetch), int'(e.flush));
      cmp(e.tag, "pc_select",   int'(bus.pc_select),   int'(e.sel));
      cmp(e.tag, "brch_full",   int'(bus.brch_full),   int'(e.full));
      cmp(e.tag, "ctrl_state",  int'(bus.ctrl_state),  int'(e.st));
      cmp(e.tag, "count",       int'(u_dut.u_cnt.count), e.cnt);
    end
  end

  // sel: SEQ0 BRNCH1 JIMM2 JREG3 RECOV4 HOLD5 EXTER6; state: IDLE0 RUN1 WAIT2 RECOVER3
  task automatic expect_now(input string tag, input logic [15:0] pc, input logic v,
                            input logic f, input logic [2:0] s, input logic full,
                            input logic [1:0] st, input int cnt);
    exp_t e;
    e.tag = tag; e.pc = pc; e.valid = v; e.flush = f; e.sel = s;
    e.full = full; e.st = st; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic clear_inputs();
    bus.stall_fetch = 0;           bus.has_mispredict = 0;
    bus.exter_pc_en = 0;           bus.brnch_issue = 2'd0;
    bus.brnch_tkn = 0;             bus.decr_count_brnch = 0;
    bus.jump_imm = 0;              bus.jump_reg = 0;
    bus.jump_base_rdy_from_rf = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    bus.pc_recovery = '0;  bus.exter_pc = '0;   bus.brnch_target = '0;
    bus.jump_imm_target = '0; bus.jump_base_from_rf = '0;
    @(posedge clk); #1;

    expect_now("reset", 16'h0000, 0, 0, 3'd5, 0, 2'd0, 0); tick();
    rst = 1'b0;
    expect_now("idle", 16'h0000, 0, 0, 3'd5, 0, 2'd0, 0); tick();
    expect_now("seq0", 16'h0000, 1, 0, 3'd0, 0, 2'd1, 0); tick();
    expect_now("seq4", 16'h0004, 1, 0, 3'd0, 0, 2'd1, 0); tick();

    bus.brnch_tkn = 1; bus.brnch_issue = 2'd1; bus.brnch_target = 16'h0040;
    expect_now("brtkn", 16'h0008, 1, 0, 3'd1, 0, 2'd1, 0); tick();
    bus.jump_imm = 1; bus.jump_imm_target = 16'h0010;
    expect_now("jimm", 16'h0040, 1, 0, 3'd2, 0, 2'd1, 1); tick();

    bus.jump_reg = 1;
    expect_now("jreg_acc", 16'h0010, 1, 0, 3'd5, 0, 2'd1, 1); tick();
    for (int i = 0; i < 3; i++) begin
      expect_now("jwait", 16'h0010, 0, 1, 3'd5, 0, 2'd2, 1); tick();
    end
    bus.jump_base_rdy_from_rf = 1; bus.jump_base_from_rf = 16'h0080;
    expect_now("jbase", 16'h0010, 0, 1, 3'd3, 0, 2'd2, 1); tick();
    expect_now("jtarget", 16'h0080, 1, 0, 3'd0, 0, 2'd1, 1); tick();

    bus.jump_reg = 1;
    expect_now("jreg2", 16'h0084, 1, 0, 3'd5, 0, 2'd1, 1); tick();
    expect_now("jwait2", 16'h0084, 0, 1, 3'd5, 0, 2'd2, 1); tick();
    bus.has_mispredict = 1; bus.pc_recovery = 16'h0020;
    expect_now("mispred", 16'h0084, 0, 1, 3'd4, 0, 2'd2, 1); tick();
    expect_now("bubble", 16'h0020, 0, 1, 3'd5, 0, 2'd3, 0); tick();

    bus.brnch_issue = 2'd2;
    expect_now("issue2", 16'h0020, 1, 0, 3'd0, 0, 2'd1, 0); tick();
    bus.brnch_issue = 2'd1;
    expect_now("issue1", 16'h0024, 1, 0, 3'd0, 0, 2'd1, 2); tick();
    expect_now("full", 16'h0028, 1, 0, 3'd5, 1, 2'd1, 3); tick();
    bus.decr_count_brnch = 1;
    expect_now("full_decr", 16'h0028, 1, 0, 3'd5, 1, 2'd1, 3); tick();
    expect_now("resume", 16'h0028, 1, 0, 3'd0, 0, 2'd1, 2); tick();
    bus.stall_fetch = 1;
    expect_now("stall", 16'h002C, 1, 0, 3'd5, 0, 2'd1, 2); tick();
    bus.brnch_issue = 2'd1; bus.decr_count_brnch = 1;
    expect_now("net", 16'h002C, 1, 0, 3'd0, 0, 2'd1, 2); tick();

    bus.exter_pc_en = 1; bus.exter_pc = 16'hFFF8;
    bus.has_mispredict = 1; bus.pc_recovery = 16'h1234; bus.decr_count_brnch = 1;
    expect_now("exter_win", 16'h0030, 1, 0, 3'd6, 0, 2'd1, 2); tick();
    expect_now("wrap0", 16'hFFF8, 1, 0, 3'd0, 0, 2'd1, 0); tick();
    expect_now("wrap1", 16'hFFFC, 1, 0, 3'd0, 0, 2'd1, 0); tick();
    expect_now("wrap2", 16'h0000, 1, 0, 3'd0, 0, 2'd1, 0); tick();

    rst = 1'b1;
    expect_now("arst", 16'h0000, 0, 0, 3'd5, 0, 2'd0, 0); tick();
    rst = 1'b0;
    expect_now("arst_idle", 16'h0000, 0, 0, 3'd5, 0, 2'd0, 0); tick();
    expect_now("arst_run", 16'h0000, 1, 0, 3'd0, 0, 2'd1, 0); tick();

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Next-PC controller for the 4-wide fetch stage. It owns the fetch PC register and picks each cycle's next fetch address from external override, ROB recovery, register-jump resolution, immediate jump, predicted-taken branch, or sequential +4. It sequences the register-jump wait and the post-mispredict flush bubble. It also tracks in-flight predicted branches so fetch throttles before the branch tracking resources overflow.

## Interface
- PC_WIDTH, 16, fetch address width
- MAX_BRNCH, 4, maximum unresolved branches in flight (≥2)
- RESET_PC, 16'h0000, fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- stall_fetch  in  1  decode back-pressure; hold current bundle
- has_mispredict  in  1  ROB redirect request
- pc_recovery  in  PC_WIDTH  redirect target
- exter_pc_en  in  1  external PC override (test)
- exter_pc  in  PC_WIDTH  override target
- brnch_issue  in  2  branches (0–2) in current bundle
- brnch_tkn  in  1  predictor says a bundle branch is taken
- brnch_target  in  PC_WIDTH  taken-branch target
- decr_count_brnch  in  1  ROB retired/resolved one branch
- jump_imm  in  1  immediate jump in bundle
- jump_imm_target  in  PC_WIDTH  its target
- jump_reg  in  1  register jump in bundle, base not yet known
- jump_base_rdy_from_rf  in  1  register base valid
- jump_base_from_rf  in  PC_WIDTH  register base = target
- fetch_pc  out  PC_WIDTH  current fetch address (registered)
- fetch_valid  out  1  bundle at fetch_pc is live
- flush_fetch  out  1  discard instruction-memory output this cycle
- pc_select  out  3  source chosen for next PC (encoding in package)
- brch_full  out  1  fewer than 2 branch slots free
- ctrl_state  out  2  FSM state, debug

## Operation
- FSM states: IDLE, RUN, WAIT_JBASE, RECOVER.
- Bundle accepted when state=RUN, fetch_valid=1, stall_fetch=0, brch_full=0.
- Next-PC priority (highest first):
  1. exter_pc_en: fetch_pc←exter_pc, state→RUN, counter cleared, sel EXTER.
  2. has_mispredict: fetch_pc←pc_recovery, state→RECOVER, counter cleared, sel RECOV. This applies in any state and aborts WAIT_JBASE.
  3. WAIT_JBASE: if jump_base_rdy_from_rf, fetch_pc←jump_base_from_rf, state→RUN, sel JREG. Otherwise hold.
  4. Not accepted (stall or brch_full): hold, sel HOLD.
  5. Accepted with jump_reg: hold fetch_pc, state→WAIT_JBASE.
  6. Accepted with jump_imm: jump_imm_target, sel JIMM.
  7. Accepted with brnch_tkn: brnch_target, sel BRNCH.
  8. Accepted otherwise: fetch_pc+4, mod 2^PC_WIDTH, sel SEQ.
- fetch_valid=1 only in RUN. flush_fetch=1 in RECOVER and WAIT_JBASE.
- RECOVER lasts exactly one cycle, then RUN.
- IDLE→RUN on the first edge after rst deasserts.
- Branch counter: width clog2(MAX_BRNCH+1).
  - next = count + (accepted ? brnch_issue : 0) − decr_count_brnch.
  - Simultaneous increment and decrement are netted.
  - Decrement at 0 is ignored and raises a sim assertion.
  - brch_full = (count > MAX_BRNCH−2).
  - Mispredict and exter clear the counter; a same-cycle decrement is ignored.

## Timing
- Reset values: fetch_pc=RESET_PC, fetch_valid=0, flush_fetch=0, pc_select=HOLD, brch_full=0, ctrl_state=IDLE, counter=0.
- Selection is combinational on current inputs. fetch_pc updates on the next edge, so redirect latency is 1 cycle.
- After a mispredict there is one bubble (RECOVER), and the recovery bundle is valid 2 cycles after has_mispredict.
- Register jump: valid target bundle arrives the cycle after jump_base_rdy_from_rf.
- pc_select, flush_fetch and fetch_valid are decoded from registered state plus current inputs, with no extra latency.
- brch_full reflects the registered counter only.

## Structure
- Package fetch_pkg holds:
  - ctrl_state enum: IDLE=0, RUN=1, WAIT_JBASE=2, RECOVER=3.
  - pc_select codes: SEQ=0, BRNCH=1, JIMM=2, JREG=3, RECOV=4, HOLD=5, EXTER=6.
  - Constant FETCH_STRIDE=4.
- One sub-module, brnch_inflight_cnt, implements the counter and brch_full. The FSM and PC mux stay in the top module.

## Test plan
- Reset, release, run 3 unstalled cycles: fetch_pc 0→4→8→12, fetch_valid=1 from cycle 2, pc_select=SEQ.
- At fetch_pc=8, brnch_tkn=1, brnch_target=0x40, brnch_issue=1: next fetch_pc=0x40, counter=1.
- Assert jump_reg at 0x10, then hold rdy low 3 cycles and give base 0x80: fetch_valid=0 and flush_fetch=1 for 3 cycles, then fetch_pc=0x80 and RUN.
- During WAIT_JBASE, has_mispredict with pc_recovery=0x20: state→RECOVER, one bubble, then fetch_pc=0x20 valid, counter=0.
- MAX_BRNCH=4: accept bundles with brnch_issue=2 and 1 → count=3, brch_full=1, fetch_pc held. Then decr_count_brnch → count=2, brch_full=0, fetch resumes.
- fetch_pc=0xFFFC sequential → 0x0000. Simultaneous exter_pc_en and has_mispredict → exter_pc wins.
